// File: rtl/uart_bus_master.sv
// UART command decoder that issues single-word reads/writes on a valid/ready memory bus.
// Optional bus-wait abort is enabled by defining UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic [1:0]  resp_last;
    logic        is_write;
    logic [23:0] rdata_q;
    logic        rx_fire, tx_fire, bus_done, bus_abort, bad_op;

    assign rx_fire   = rx_tvalid && rx_tready;
    assign tx_fire   = tx_tvalid && tx_tready;
    assign bus_done  = (state == BUS) && mem_ready;
    assign bad_op    = (rx_tdata != OP_WRITE) && (rx_tdata != OP_READ);
    assign mem_instr = 1'b0;
    assign busy      = (state != IDLE);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counter sits at zero outside BUS so it starts from zero on every bus entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state != BUS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign bus_abort = (state == BUS) && !mem_ready && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign bus_abort      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_fire) state_next = bad_op ? RESP : ADDR;
            ADDR: if (rx_fire && cnt == 2'd3) state_next = is_write ? DATA : BUS;
            DATA: if (rx_fire && cnt == 2'd3) state_next = BUS;
            BUS:  if (bus_done || bus_abort) state_next = RESP;
            RESP: if (tx_fire && cnt == resp_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_tready <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
            cnt       <= '0;
            resp_last <= '0;
            is_write  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rx_tready <= (state_next == IDLE) || (state_next == ADDR) || (state_next == DATA);
            mem_valid <= (state_next == BUS);
            mem_wstrb <= ((state_next == BUS) && is_write) ? 4'hF : 4'h0;
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        is_write <= (rx_tdata == OP_WRITE);
                        if (bad_op) begin
                            tx_tvalid <= 1'b1;
                            tx_tdata  <= RSP_NAK;
                            resp_last <= 2'd0;
                        end
                    end
                end
                ADDR: begin
                    // Low two bits only ever shift downwards, so zeroing them each step is safe.
                    if (rx_fire) begin
                        mem_addr <= {rx_tdata, mem_addr[31:10], 2'b00};
                        cnt      <= cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        mem_wdata <= {rx_tdata, mem_wdata[31:8]};
                        cnt       <= cnt + 2'd1;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        tx_tvalid <= 1'b1;
                        rdata_q   <= mem_rdata[31:8];
                        if (is_write) begin
                            tx_tdata  <= RSP_ACK;
                            resp_last <= 2'd0;
                        end else begin
                            tx_tdata  <= mem_rdata[7:0];
                            resp_last <= 2'd3;
                        end
                    end else if (bus_abort) begin
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= RSP_NAK;
                        resp_last <= 2'd0;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        if (cnt == resp_last) begin
                            tx_tvalid <= 1'b0;
                            cnt       <= 2'd0;
                        end else begin
                            tx_tdata <= rdata_q[7:0];
                            rdata_q  <= {8'h00, rdata_q[23:8]};
                            cnt      <= cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: framing, bus handshake, response backpressure,
// reset recovery and bus-wait abort when UART_BUS_MASTER_TIMEOUT_EN is defined.
module tb_uart_bus_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int assertCount = 0;
    int failCount   = 0;

    int          readyDelay = 0;
    logic [31:0] respData   = 32'h0;
    bit          respEnable = 1'b1;

    int          reqCount    = 0;
    int          validCycles = 0;
    int          stableErr   = 0;
    int          waitCnt     = 0;
    logic        prevValid   = 1'b0;
    logic [31:0] capAddr     = 32'h0;
    logic [31:0] capWdata    = 32'h0;
    logic [3:0]  capWstrb    = 4'h0;

    // Responder and bus monitor, sampled on the falling edge away from DUT updates.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                if (prevValid !== 1'b1) begin
                    reqCount++;
                    waitCnt  = 0;
                    capAddr  = mem_addr;
                    capWdata = mem_wdata;
                    capWstrb = mem_wstrb;
                end else begin
                    waitCnt++;
                    if (mem_addr !== capAddr || mem_wdata !== capWdata || mem_wstrb !== capWstrb)
                        stableErr++;
                end
                validCycles++;
            end
            prevValid = mem_valid;
            if (mem_valid === 1'b1 && respEnable && waitCnt == readyDelay) begin
                mem_ready = 1'b1;
                mem_rdata = respData;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        while (rx_tready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (rx_tready !== 1'b1) checkOutput("rx_ready_wait", 32'(rx_tready), 32'd1);
        @(posedge clk); #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic sendCmd(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(bytes[i]);
    endtask

    task automatic waitTxValid(output int cycles);
        cycles = 0;
        while (tx_tvalid !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (tx_tvalid !== 1'b1) checkOutput("tx_valid_wait", 32'(tx_tvalid), 32'd1);
    endtask

    task automatic acceptTx(input string tag, input logic [7:0] expected);
        int c;
        waitTxValid(c);
        checkOutput(tag, 32'(tx_tdata), 32'(expected));
        tx_tready = 1'b1;
        @(posedge clk); #1;
        tx_tready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({mem_valid, mem_wstrb, tx_tvalid, rx_tready, busy, mem_instr}), 32'd0);
        checkOutput({tag, "_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_tdata"}, 32'(tx_tdata), 32'h0);
    endtask

    initial begin
        logic [7:0] cmd[$];
        logic [7:0] rdExp[4];
        int c, r0, v0, s0, unstable;

        resetn    = 1'b0;
        rx_tdata  = 8'h00;
        rx_tvalid = 1'b0;
        tx_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_rx_ready", 32'(rx_tready), 32'd1);
        checkOutput("release_busy", 32'(busy), 32'd0);

        $display("[TB] write command");
        readyDelay = 2;
        respEnable = 1'b1;
        r0 = reqCount; v0 = validCycles; s0 = stableErr;
        cmd = '{8'h57, 8'h03, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sendCmd(cmd);
        checkOutput("wr_valid_rise", 32'(mem_valid), 32'd1);
        checkOutput("wr_rx_ready_low", 32'(rx_tready), 32'd0);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        waitTxValid(c);
        checkOutput("wr_resp_latency", c, 32'd3);
        checkOutput("wr_valid_drop", 32'(mem_valid), 32'd0);
        acceptTx("wr_ack", 8'h06);
        checkOutput("wr_tx_done", 32'(tx_tvalid), 32'd0);
        checkOutput("wr_rx_ready_back", 32'(rx_tready), 32'd1);
        checkOutput("wr_req_count", reqCount - r0, 32'd1);
        checkOutput("wr_valid_cycles", validCycles - v0, 32'd3);
        checkOutput("wr_addr", capAddr, 32'h0000_0100);
        checkOutput("wr_wdata", capWdata, 32'hDEAD_BEEF);
        checkOutput("wr_wstrb", 32'(capWstrb), 32'hF);
        checkOutput("wr_stable", stableErr - s0, 32'd0);

        $display("[TB] read command, same-cycle ready");
        readyDelay = 0;
        respData   = 32'h1234_5678;
        tx_tready  = 1'b1;
        r0 = reqCount; v0 = validCycles;
        cmd = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        sendCmd(cmd);
        waitTxValid(c);
        checkOutput("rd_resp_latency", c, 32'd1);
        rdExp = '{8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd_stream_valid", 32'(tx_tvalid), 32'd1);
            checkOutput("rd_stream_data", 32'(tx_tdata), 32'(rdExp[i]));
            @(posedge clk); #1;
        end
        checkOutput("rd_stream_end", 32'(tx_tvalid), 32'd0);
        tx_tready = 1'b0;
        checkOutput("rd_req_count", reqCount - r0, 32'd1);
        checkOutput("rd_valid_cycles", validCycles - v0, 32'd1);
        checkOutput("rd_addr", capAddr, 32'h0000_0100);
        checkOutput("rd_wstrb", 32'(capWstrb), 32'h0);

        $display("[TB] bad opcode");
        r0 = reqCount;
        applyStimulus(8'h41);
        checkOutput("nak_valid", 32'(tx_tvalid), 32'd1);
        checkOutput("nak_data", 32'(tx_tdata), 32'h15);
        checkOutput("nak_rx_ready_low", 32'(rx_tready), 32'd0);
        acceptTx("nak_accept", 8'h15);
        checkOutput("nak_rx_ready_back", 32'(rx_tready), 32'd1);
        checkOutput("nak_tx_done", 32'(tx_tvalid), 32'd0);
        checkOutput("nak_no_bus", reqCount - r0, 32'd0);

        $display("[TB] read response backpressure");
        readyDelay = 1;
        respData   = 32'hA1B2_C3D4;
        cmd = '{8'h52, 8'h05, 8'h00, 8'h00, 8'h20};
        sendCmd(cmd);
        waitTxValid(c);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hD4) unstable++;
            @(posedge clk); #1;
        end
        checkOutput("bp_hold_stable", unstable, 32'd0);
        checkOutput("bp_addr", capAddr, 32'h2000_0004);
        rdExp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int i = 0; i < 4; i++) begin
            acceptTx("bp_byte", rdExp[i]);
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_no_extra", 32'(tx_tvalid), 32'd0);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        $display("[TB] bus timeout");
        respEnable = 1'b0;
        v0 = validCycles;
        cmd = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        sendCmd(cmd);
        waitTxValid(c);
        checkOutput("tmo_valid_cycles", validCycles - v0, TMO);
        checkOutput("tmo_valid_drop", 32'(mem_valid), 32'd0);
        acceptTx("tmo_nak", 8'h15);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("tmo_single_byte", 32'(tx_tvalid), 32'd0);
        respEnable = 1'b1;
`else
        $display("[TB] no timeout: bus waits");
        respEnable = 1'b0;
        cmd = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        sendCmd(cmd);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("wait_valid_held", 32'(mem_valid), 32'd1);
        checkOutput("wait_no_resp", 32'(tx_tvalid), 32'd0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("wait_reset_valid", 32'(mem_valid), 32'd0);
        resetn = 1'b1;
        respEnable = 1'b1;
        @(posedge clk); #1;
`endif

        $display("[TB] reset mid-command");
        cmd = '{8'h52, 8'h00, 8'h01};
        sendCmd(cmd);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("midreset");
        resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_rx_ready", 32'(rx_tready), 32'd1);
        readyDelay = 2;
        r0 = reqCount;
        cmd = '{8'h57, 8'h08, 8'h00, 8'h00, 8'h10, 8'h44, 8'h33, 8'h22, 8'h11};
        sendCmd(cmd);
        acceptTx("midreset_ack", 8'h06);
        checkOutput("midreset_req_count", reqCount - r0, 32'd1);
        checkOutput("midreset_addr", capAddr, 32'h1000_0008);
        checkOutput("midreset_wdata", capWdata, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

UART-driven initiator for the picorv32-style native memory bus (`mem_valid`/`mem_ready` handshake). It consumes command bytes from the UART receive AXI-stream and issues single-word reads and writes into the system memory map (RAM, `0x1000_0000` byte port, `0x2000_00xx` UART/GPIO registers). It returns ACK, NAK or read data bytes on the UART transmit AXI-stream. The block sits beside the CPU on the shared responder as a debug/boot-load path; arbitration against the CPU is outside this block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: number of bus-wait cycles before abort. Only used with the timeout macro. Legal range is 2..65535.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `resetn` in 1: synchronous, active-low reset.
- `rx_tdata` in 8: command byte from the UART receiver.
- `rx_tvalid` in 1: receive byte valid.
- `rx_tready` out 1: this block accepts the receive byte.
- `tx_tdata` out 8: response byte to the UART transmitter.
- `tx_tvalid` out 1: response byte valid.
- `tx_tready` in 1: transmitter accepts the byte.
- `mem_valid` out 1: bus request.
- `mem_instr` out 1: tied to 0.
- `mem_ready` in 1: responder done.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: `1111` for a write, `0000` for a read.
- `mem_rdata` in 32: read data. Valid when `mem_ready` is high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Byte transfer on either stream occurs only on a rising edge where `tvalid && tready`.
- Command format. All multi-byte fields are little-endian.
  - Write: `0x57` ('W'), then addr[7:0], [15:8], [23:16], [31:24], then data[7:0] .. data[31:24]. Response: `0x06`.
  - Read: `0x52` ('R'), then 4 address bytes. Response: 4 data bytes, LSB first.
  - Any other opcode byte: response `0x15` (NAK). No bus cycle is issued.
- Address bits [1:0] are forced to 0 on `mem_addr`.
- States and transitions:
  - IDLE: accept the opcode. 'W' or 'R' goes to ADDR; any other opcode goes to RESP with NAK.
  - ADDR: accept 4 bytes (2-bit counter). Then go to DATA for a write, or BUS for a read.
  - DATA: accept 4 bytes, then go to BUS.
  - BUS: drive the request. On `mem_ready` go to RESP.
  - RESP: emit 1 or 4 bytes (byte counter). After the final byte is accepted, go to IDLE.
- `rx_tready` is registered. It is 1 exactly while the state is IDLE, ADDR or DATA, and 0 in BUS and RESP.
- Bus rules (responder-compatible):
  - `mem_valid` rises the cycle after the final command byte is accepted.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_valid` is high.
  - On the edge that samples `mem_valid && mem_ready`: capture `mem_rdata`, and `mem_valid` is low in the next cycle.
  - A new request never starts in the cycle immediately after `mem_ready`.
- Response: `tx_tvalid` asserts the cycle after the bus completes. `tx_tdata` is held stable until accepted. `tx_tvalid` stays high between consecutive read-data bytes when `tx_tready` is held high.
- Reset: while `resetn` is low at an edge, all of the following are 0 from the next cycle: `mem_valid`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `tx_tvalid`, `tx_tdata`, `rx_tready`, `busy`, and all counters. State returns to IDLE.
  - Reset mid-command discards the partial command and any pending response.
  - `rx_tready` is 1 in the first cycle after release.

## Timing
- Write command: the last data byte is accepted at edge N, so `mem_valid` is high in N+1. Responder ready is sampled at edge M, so `mem_valid` is low and `tx_tvalid` high with `0x06` in M+1.
- Read command: the same timing, with byte 0 = rdata[7:0] in M+1. Each further byte appears the cycle after the previous byte is accepted.
- Minimum throughput: 1 byte per cycle on both streams. No internal bubbles on `rx_tready` within a command.
- `mem_ready` arriving the same cycle `mem_valid` first rises is legal. It completes with 1-cycle bus occupancy.

## Configuration
- `UART_BUS_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears when BUS is entered and increments each BUS cycle.
  - If `mem_ready` is still low when the counter equals `TIMEOUT_CYCLES-1`, `mem_valid` drops the next cycle and the response is a single `0x15` (no data bytes, including for a read).
  - `mem_ready` high in the expiry cycle counts as completion; ready wins over the timeout.
- Not defined: no counter is present, and BUS waits indefinitely for `mem_ready`.

## Test plan
- Write: RX `57 03 01 00 00 EF BE AD DE`, ready after 2 cycles -> one bus cycle with addr `0x00000100`, wdata `0xDEADBEEF`, wstrb `1111`. TX `06`.
- Read: RX `52 00 01 00 00`, `mem_rdata=0x12345678` -> wstrb `0000`, addr `0x00000100`. TX `78 56 34 12` in 4 consecutive cycles with `tx_tready` held high.
- Bad opcode `41` -> TX `15`, no `mem_valid` pulse, and `rx_tready` back to 1 after the accept.
- Backpressure: hold `tx_tready` low for 10 cycles during a read response -> `tx_tdata` is stable and `tx_tvalid` held, with no byte lost or duplicated.
- Timeout (macro on, `TIMEOUT_CYCLES=16`), `mem_ready` held low -> `mem_valid` high exactly 16 cycles, then TX `15`. With the macro off, the same stimulus leaves `mem_valid` high indefinitely.
- Reset after `52 00 01` -> all outputs 0. A following full write command completes normally with TX `06`.
